// File: rtl/rename_map_table_pkg.sv
// Shared rename definitions: register counts and widths, recovery FSM encoding, table write payload.
package rename_map_table_pkg;

   localparam int unsigned NUM_AR = 32;
   localparam int unsigned NUM_PR = 64;
   localparam int unsigned AR_W   = 5;
   localparam int unsigned PR_W   = 6;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WALK  = 2'd1,
      DRAIN = 2'd2
   } rec_state_e;

   typedef struct packed {
      logic [AR_W-1:0] ar;
      logic [PR_W-1:0] pr;
   } map_wr_t;

endpackage

// File: rtl/rename_ready_table.sv
// Per-PR ready bits: cleared on allocation, set on CDB writeback, reads bypass a same-cycle CDB hit.
module rename_ready_table
   import rename_map_table_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc_en,
   input  logic [PR_W-1:0] alloc_PR,
   input  logic            cdb_valid,
   input  logic [PR_W-1:0] cdb_PR,
   input  logic [PR_W-1:0] rd_a_PR,
   input  logic [PR_W-1:0] rd_b_PR,
   output logic            rd_a_ready,
   output logic            rd_b_ready
);

   logic [NUM_PR-1:0] ready_q;

   // Allocation clear is applied last so it wins over a same-PR writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= '1;
      end else begin
         if (cdb_valid) ready_q[cdb_PR] <= 1'b1;
         if (alloc_en)  ready_q[alloc_PR] <= 1'b0;
      end
   end

   assign rd_a_ready = ready_q[rd_a_PR] | (cdb_valid & (cdb_PR == rd_a_PR));
   assign rd_b_ready = ready_q[rd_b_PR] | (cdb_valid & (cdb_PR == rd_b_PR));

endmodule

// File: rtl/rename_map_table.sv
// AR->PR register alias table with youngest-first branch-recovery restore.
// Optional per-PR ready bits with CDB bypass when RENAME_READY_BIT_EN is defined.
module rename_map_table
   import rename_map_table_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [AR_W-1:0] rs,
   input  logic [AR_W-1:0] rt,
   input  logic [AR_W-1:0] rd,
   input  logic            RegDest,
   input  logic            hazard_stall,
   input  logic [PR_W-1:0] PR_new,
   input  logic            empty,
   input  logic            recover,
   input  logic [AR_W-1:0] rd_flush,
   input  logic [PR_W-1:0] PR_old_flush,
   input  logic            RegDest_ROB,
   input  logic            cdb_valid,
   input  logic [PR_W-1:0] cdb_PR,
   output logic [PR_W-1:0] PR_rs,
   output logic [PR_W-1:0] PR_rt,
   output logic [PR_W-1:0] PR_old,
   output logic [PR_W-1:0] PR_rd,
   output logic            rename_en,
   output logic            rename_stall,
   output logic            rs_ready,
   output logic            rt_ready
);

   logic [PR_W-1:0] map_q [NUM_AR];
   rec_state_e      state_q;
   rec_state_e      state_d;
   logic            wr_en;
   map_wr_t         wr;

   // Recovery FSM next state, rename/restore write selection and stall.
   always_comb begin
      state_d      = state_q;
      rename_en    = 1'b0;
      rename_stall = 1'b0;
      wr_en        = 1'b0;
      wr           = '0;

      case (state_q)
         RUN:     if (recover)  state_d = WALK;
         WALK:    if (!recover) state_d = DRAIN;
         DRAIN:   state_d = RUN;
         default: state_d = RUN;
      endcase

      rename_en    = RegDest & ~empty & ~hazard_stall & (state_q == RUN) & ~recover;
      rename_stall = (RegDest & empty) | (state_q != RUN);

      // Restore writes start with the first recover cycle and outrank renames.
      if (recover & RegDest_ROB & ~hazard_stall) begin
         wr_en = 1'b1;
         wr    = '{ar: rd_flush, pr: PR_old_flush};
      end else if (rename_en) begin
         wr_en = 1'b1;
         wr    = '{ar: rd, pr: PR_new};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         for (int i = 0; i < int'(NUM_AR); i++) map_q[i] <= PR_W'(i);
      end else begin
         state_q <= state_d;
         if (wr_en) map_q[wr.ar] <= wr.pr;
      end
   end

   // Lookups see the table before this cycle's write.
   assign PR_rs  = map_q[rs];
   assign PR_rt  = map_q[rt];
   assign PR_old = map_q[rd];
   assign PR_rd  = PR_new;

`ifdef RENAME_READY_BIT_EN
   rename_ready_table u_ready (
      .clk        (clk),
      .rst        (rst),
      .alloc_en   (rename_en),
      .alloc_PR   (PR_new),
      .cdb_valid  (cdb_valid),
      .cdb_PR     (cdb_PR),
      .rd_a_PR    (PR_rs),
      .rd_b_PR    (PR_rt),
      .rd_a_ready (rs_ready),
      .rd_b_ready (rt_ready)
   );
`else
   logic unused_cdb;
   assign unused_cdb = &{1'b0, cdb_valid, cdb_PR};
   assign rs_ready   = 1'b1;
   assign rt_ready   = 1'b1;
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Randomized scoreboard bench for rename_map_table against an array-based reference model.
module tb_rename_map_table;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs, rt, rd;
      logic       reg_dest, hz;
      logic [5:0] pr_new;
      logic       empty, recover;
      logic [4:0] rd_flush;
      logic [5:0] pr_old_flush;
      logic       rd_rob, cdb_valid;
      logic [5:0] cdb_pr;
   } stim_t;

   typedef struct packed {
      logic [5:0] pr_rs, pr_rt, pr_old, pr_rd;
      logic       ren, stall, rs_rdy, rt_rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs = '0, rt = '0, rd = '0, rd_flush = '0;
   logic       RegDest = 1'b0, hazard_stall = 1'b0, empty = 1'b0, recover = 1'b0;
   logic       RegDest_ROB = 1'b0, cdb_valid = 1'b0;
   logic [5:0] PR_new = '0, PR_old_flush = '0, cdb_PR = '0;
   logic [5:0] PR_rs, PR_rt, PR_old, PR_rd;
   logic       rename_en, rename_stall, rs_ready, rt_ready;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: plain arrays plus recovery phase flags.
   int m_map[32];
   bit m_ready[64];
   bit m_walk, m_drain;

   always #5 clk = ~clk;

   rename_map_table dut (
      .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .RegDest(RegDest),
      .hazard_stall(hazard_stall), .PR_new(PR_new), .empty(empty), .recover(recover),
      .rd_flush(rd_flush), .PR_old_flush(PR_old_flush), .RegDest_ROB(RegDest_ROB),
      .cdb_valid(cdb_valid), .cdb_PR(cdb_PR), .PR_rs(PR_rs), .PR_rt(PR_rt),
      .PR_old(PR_old), .PR_rd(PR_rd), .rename_en(rename_en), .rename_stall(rename_stall),
      .rs_ready(rs_ready), .rt_ready(rt_ready)
   );

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_map[i] = i;
      for (int i = 0; i < 64; i++) m_ready[i] = 1'b1;
      m_walk  = 1'b0;
      m_drain = 1'b0;
   endfunction

   function automatic bit model_ready(input int pr, input stim_t s);
`ifdef RENAME_READY_BIT_EN
      return m_ready[pr] | (s.cdb_valid && (int'(s.cdb_pr) == pr));
`else
      return 1'b1;
`endif
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   // Drive one cycle, push the expected outputs, then advance the model to the next edge.
   task automatic drive(input stim_t s);
      exp_t e;
      bit   in_rec;
      @(posedge clk);
      #1;
      rst = s.rst; rs = s.rs; rt = s.rt; rd = s.rd; RegDest = s.reg_dest;
      hazard_stall = s.hz; PR_new = s.pr_new; empty = s.empty; recover = s.recover;
      rd_flush = s.rd_flush; PR_old_flush = s.pr_old_flush; RegDest_ROB = s.rd_rob;
      cdb_valid = s.cdb_valid; cdb_PR = s.cdb_pr;
      if (s.rst) model_reset();
      in_rec   = m_walk | m_drain;
      e.pr_rs  = 6'(m_map[s.rs]);
      e.pr_rt  = 6'(m_map[s.rt]);
      e.pr_old = 6'(m_map[s.rd]);
      e.pr_rd  = s.pr_new;
      e.ren    = s.reg_dest & !s.empty & !s.hz & !in_rec & !s.recover;
      e.stall  = (s.reg_dest & s.empty) | in_rec;
      e.rs_rdy = model_ready(m_map[s.rs], s);
      e.rt_rdy = model_ready(m_map[s.rt], s);
      exp_q.push_back(e);
      if (s.rst) begin
         #5;
         rst = 1'b0;
      end else begin
         if (s.recover && s.rd_rob && !s.hz) m_map[s.rd_flush] = int'(s.pr_old_flush);
         else if (e.ren) m_map[s.rd] = int'(s.pr_new);
         if (s.cdb_valid) m_ready[s.cdb_pr] = 1'b1;
         if (e.ren) m_ready[s.pr_new] = 1'b0;
         if (m_drain) m_drain = 1'b0;
         else if (m_walk && !s.recover) begin m_walk = 1'b0; m_drain = 1'b1; end
         else if (!m_walk && s.recover) m_walk = 1'b1;
      end
   endtask

   task automatic rename(input int r, input int pr, input int src);
      stim_t s;
      s = idle(); s.rd = 5'(r); s.reg_dest = 1'b1; s.pr_new = 6'(pr); s.rs = 5'(src);
      drive(s);
   endtask

   task automatic lookup(input int a, input int b);
      stim_t s;
      s = idle(); s.rs = 5'(a); s.rt = 5'(b); s.rd = 5'(a);
      drive(s);
   endtask

   task automatic flush(input int r, input int pr, input bit valid);
      stim_t s;
      s = idle(); s.recover = 1'b1; s.rd_flush = 5'(r); s.pr_old_flush = 6'(pr);
      s.rd_rob = valid; s.rs = 5'(r);
      drive(s);
   endtask

   // Monitor: compares every pushed expectation at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("PR_rs", PR_rs, e.pr_rs);
            check("PR_rt", PR_rt, e.pr_rt);
            check("PR_old", PR_old, e.pr_old);
            check("PR_rd", PR_rd, e.pr_rd);
            check("rename_en", rename_en, e.ren);
            check("rename_stall", rename_stall, e.stall);
            check("rs_ready", rs_ready, e.rs_rdy);
            check("rt_ready", rt_ready, e.rt_rdy);
         end
      end
   end

   initial begin
      stim_t s;
      int    walk_left;
      model_reset();

      // Reset state, then first rename: same-cycle old mapping, next-cycle new mapping.
      s = idle(); s.rst = 1'b1; s.rs = 5'd3; s.rt = 5'd7; s.rd = 5'd3;
      drive(s);
      s = idle(); s.rs = 5'd3; s.rt = 5'd7; s.rd = 5'd3; s.reg_dest = 1'b1; s.pr_new = 6'd32;
      drive(s);
      lookup(3, 7);

      // Back-to-back renames of the same AR.
      rename(5, 40, 5);
      rename(5, 41, 5);
      lookup(5, 3);

      // Empty free list and hazard stall both block the write.
      s = idle(); s.rd = 5'd6; s.reg_dest = 1'b1; s.empty = 1'b1; s.pr_new = 6'd50;
      drive(s);
      s = idle(); s.rd = 5'd6; s.reg_dest = 1'b1; s.hz = 1'b1; s.pr_new = 6'd51;
      drive(s);
      lookup(6, 5);

      // Two-entry walk restores map[5] = 5; then an entry without a destination.
      flush(5, 40, 1'b1);
      flush(5, 5, 1'b1);
      s = idle(); s.rd = 5'd8; s.reg_dest = 1'b1; s.pr_new = 6'd45;
      drive(s); drive(s); drive(s);
      lookup(5, 8);
      flush(5, 60, 1'b0);
      lookup(5, 8); lookup(5, 8); lookup(5, 8);

      // Ready bits: allocation clear, CDB bypass, store, and clear-wins collision.
      rename(9, 33, 9);
      lookup(9, 9);
      s = idle(); s.rs = 5'd9; s.rt = 5'd9; s.cdb_valid = 1'b1; s.cdb_pr = 6'd33;
      drive(s);
      lookup(9, 9);
      s = idle(); s.rd = 5'd10; s.reg_dest = 1'b1; s.pr_new = 6'd34;
      s.cdb_valid = 1'b1; s.cdb_pr = 6'd34;
      drive(s);
      lookup(10, 9);

      // Reset in the middle of a walk.
      rename(5, 50, 5);
      flush(5, 5, 1'b1);
      flush(12, 12, 1'b1);
      s = idle(); s.rst = 1'b1; s.rs = 5'd5; s.rt = 5'd10; s.rd = 5'd9;
      drive(s);
      lookup(9, 10);

      // Random traffic with occasional recovery episodes.
      walk_left = 0;
      for (int n = 0; n < 800; n++) begin
         s = idle();
         s.rs = 5'($urandom_range(0, 31));
         s.rt = 5'($urandom_range(0, 31));
         s.rd = 5'($urandom_range(0, 31));
         s.pr_new = 6'($urandom_range(0, 63));
         s.cdb_valid = 1'($urandom_range(0, 1));
         s.cdb_pr = 6'($urandom_range(0, 63));
         if (walk_left == 0 && $urandom_range(0, 11) == 0) walk_left = $urandom_range(1, 4);
         if (walk_left > 0) begin
            walk_left--;
            s.recover = 1'b1;
            s.rd_flush = 5'($urandom_range(0, 31));
            s.pr_old_flush = 6'($urandom_range(0, 63));
            s.rd_rob = 1'($urandom_range(0, 1));
            s.hz = ($urandom_range(0, 4) == 0);
            s.reg_dest = (s.rd != 5'd0) && ($urandom_range(0, 1) == 1);
         end else begin
            s.reg_dest = (s.rd != 5'd0) && ($urandom_range(0, 3) != 0);
            s.empty = ($urandom_range(0, 7) == 0);
            s.hz = ($urandom_range(0, 7) == 0);
         end
         drive(s);
      end

      // Final sweep of every table entry.
      for (int i = 0; i < 32; i++) lookup(i, 31 - i);

      @(negedge clk);
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
